// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV32I load/store requests into
// word-addressed, byte-enabled memory cycles. Accesses that straddle a word
// boundary are split into two cycles. Load data comes back aligned and
// extended. Out-of-range and illegal-size requests are answered with an
// error and never reach memory.
module load_store_unit #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic                  we,
    output logic [3:0]            mem_op,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [31:0]           data_write,
    input  logic [31:0]           data_read
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        ISSUE_HI,
        COLLECT,
        RESP
    } state_t;

    state_t state;

    // Request fields held for the duration of an access
    logic                  cur_store;
    logic [1:0]            cur_size;
    logic                  cur_unsigned;
    logic [1:0]            cur_offset;
    logic                  cur_split;
    logic [3:0]            cur_hi_mask;
    logic [31:0]           cur_hi_data;
    logic [ADDR_WIDTH-1:0] cur_hi_addr;
    logic [31:0]           lo_word;

    // Decode of the incoming request
    logic [1:0]            offset;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [3:0]            size_mask;
    logic [7:0]            lane_mask;
    logic [63:0]           lane_data;
    logic                  split;
    logic                  range_err;
    logic                  wrap_err;
    logic                  req_err;

    // Load assembly
    logic [31:0] load_lo;
    logic [31:0] load_hi;
    logic [31:0] load_shifted;
    logic [31:0] load_result;

    // Decode offset, byte-enable mask, lane-shifted write data and error causes
    always_comb begin
        offset    = req_addr[1:0];
        word_addr = req_addr[ADDR_WIDTH+1:2];
        case (req_size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
        lane_mask = {4'b0000, size_mask} << offset;
        lane_data = {32'h0, req_wdata} << {offset, 3'b000};
        split     = |lane_mask[7:4];
        range_err = |req_addr[31:ADDR_WIDTH+2];
        // The second half of a split access at the top word would wrap to 0
        wrap_err  = split && (word_addr == {ADDR_WIDTH{1'b1}});
        req_err   = (req_size == 2'b11) || range_err || wrap_err;
    end

    // Align the (possibly two-word) read data and extend it to 32 bits
    always_comb begin
        if (cur_split) begin
            load_lo = lo_word;
            load_hi = data_read;
        end else begin
            load_lo = data_read;
            load_hi = 32'h0;
        end
        load_shifted = 32'({load_hi, load_lo} >> {cur_offset, 3'b000});
        case (cur_size)
            2'b00:   load_result = cur_unsigned ? {24'h0, load_shifted[7:0]}
                                                : {{24{load_shifted[7]}}, load_shifted[7:0]};
            2'b01:   load_result = cur_unsigned ? {16'h0, load_shifted[15:0]}
                                                : {{16{load_shifted[15]}}, load_shifted[15:0]};
            default: load_result = load_shifted;
        endcase
    end

    // Access sequencer; all memory and response outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= 32'h0;
            we           <= 1'b0;
            mem_op       <= 4'b0000;
            data_addr    <= '0;
            data_write   <= 32'h0;
            cur_store    <= 1'b0;
            cur_size     <= 2'b00;
            cur_unsigned <= 1'b0;
            cur_offset   <= 2'b00;
            cur_split    <= 1'b0;
            cur_hi_mask  <= 4'b0000;
            cur_hi_data  <= 32'h0;
            cur_hi_addr  <= '0;
            lo_word      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready    <= 1'b0;
                        cur_store    <= req_store;
                        cur_size     <= req_size;
                        cur_unsigned <= req_unsigned;
                        cur_offset   <= offset;
                        cur_split    <= split;
                        cur_hi_mask  <= lane_mask[7:4];
                        cur_hi_data  <= lane_data[63:32];
                        cur_hi_addr  <= word_addr + ADDR_WIDTH'(1);
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state      <= ISSUE_LO;
                            we         <= req_store;
                            mem_op     <= lane_mask[3:0];
                            data_addr  <= word_addr;
                            data_write <= lane_data[31:0];
                        end
                    end
                end
                ISSUE_LO: begin
                    if (cur_split) begin
                        state      <= ISSUE_HI;
                        we         <= cur_store;
                        mem_op     <= cur_hi_mask;
                        data_addr  <= cur_hi_addr;
                        data_write <= cur_hi_data;
                    end else begin
                        we     <= 1'b0;
                        mem_op <= 4'b0000;
                        if (cur_store) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'h0;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                ISSUE_HI: begin
                    // Read data for the low word arrives while the high word is addressed
                    lo_word <= data_read;
                    we      <= 1'b0;
                    mem_op  <= 4'b0000;
                    if (cur_store) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                    end else begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_result;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    we         <= 1'b0;
                    mem_op     <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a byte-lane memory attached to the memory
// port, a byte-level reference memory, and a scoreboard of expected
// responses and expected memory writes.
module tb_load_store_unit;

    localparam int AW = 12;

    typedef struct packed {
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          we;
    logic [3:0]    mem_op;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_write;
    logic [31:0]   data_read;

    int checks = 0;
    int failures = 0;

    exp_t        exp_q[$];
    logic [47:0] exp_wr[$];
    logic [47:0] obs_wr[$];

    logic [31:0] mem [0:(1<<AW)-1];
    logic [7:0]  ref_mem [0:(4<<AW)-1];
    bit          mem_init_done = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_store(req_store),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .we(we),
        .mem_op(mem_op),
        .data_addr(data_addr),
        .data_write(data_write),
        .data_read(data_read)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Synchronous byte-lane memory; filled with a known pattern on the first edge
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (mem_op[b]) mem[data_addr][8*b +: 8] <= data_write[8*b +: 8];
        end
        data_read <= mem[data_addr];
    end

    // Record every memory write cycle the DUT issues
    always @(negedge clk) begin
        if (we) obs_wr.push_back({data_addr, mem_op, data_write});
    end

    // Reference model: push expected response and writes, update reference memory
    task automatic predict(input req_t r);
        exp_t        e;
        int          n;
        int          o;
        int          ba;
        logic [11:0] w;
        logic [7:0]  be;
        logic [63:0] lanes;
        logic [31:0] v;
        logic        spl;
        n  = (r.sz == 2'd0) ? 1 : (r.sz == 2'd1) ? 2 : 4;
        o  = int'(r.addr[1:0]);
        w  = r.addr[13:2];
        ba = int'(r.addr[13:0]);
        spl = (o + n) > 4;
        e.err   = (r.sz == 2'd3) || (r.addr[31:14] != 0) || (spl && w == 12'hFFF);
        e.rdata = 32'h0;
        e.lat   = 1;
        if (!e.err) begin
            if (r.st) begin
                e.lat = spl ? 3 : 2;
                lanes = {32'h0, r.wd} << (8 * o);
                be    = 8'(((1 << n) - 1) << o);
                exp_wr.push_back({w, be[3:0], lanes[31:0]});
                if (spl) exp_wr.push_back({12'(w + 12'd1), be[7:4], lanes[63:32]});
                for (int i = 0; i < n; i++) ref_mem[ba + i] = r.wd[8*i +: 8];
            end else begin
                e.lat = spl ? 4 : 3;
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[ba + i];
                if (!r.uns && n < 4 && v[8*n-1])
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
        exp_q.push_back(e);
    endtask

    // Drive one request and wait (bounded) for its response
    task automatic issue(input req_t r, output logic err, output logic [31:0] rd,
                         output int lat, output logic busy_ready, output int stall);
        stall = 0;
        @(negedge clk);
        while (!req_ready && stall < 10) begin
            @(negedge clk);
            stall++;
        end
        req_valid    = 1'b1;
        req_store    = r.st;
        req_size     = r.sz;
        req_unsigned = r.uns;
        req_addr     = r.addr;
        req_wdata    = r.wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        err = 1'bx;
        rd  = 32'hxxxxxxxx;
        busy_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (req_ready) busy_ready = 1'b1;
            if (resp_valid) begin
                lat = c;
                err = resp_err;
                rd  = resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < (4 << AW); i++) ref_mem[i] = init_word(i / 4)[8*(i%4) +: 8];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", we); end
        checks++; if (mem_op !== 4'h0) begin failures++; $display("FAIL reset_mem_op got=%b exp=0000", mem_op); end
        checks++; if (data_addr !== '0) begin failures++; $display("FAIL reset_data_addr got=%h exp=0", data_addr); end
        checks++; if (data_write !== 32'h0) begin failures++; $display("FAIL reset_data_write got=%h exp=0", data_write); end
        $display("reset: req_ready=%b resp_valid=%b we=%b mem_op=%b", req_ready, resp_valid, we, mem_op);
    endtask

    task automatic test_aligned;
        req_t tbl[$];
        exp_t e;
        logic o_err, o_busy;
        logic [31:0] o_rd;
        int o_lat, o_stall;
        logic [47:0] ew, ow;
        tbl = '{'{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF},
                '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0},
                '{1'b1, 2'd1, 1'b0, 32'h16, 32'h0000BEEF},
                '{1'b0, 2'd1, 1'b0, 32'h16, 32'h0}};
        foreach (tbl[i]) begin
            predict(tbl[i]);
            issue(tbl[i], o_err, o_rd, o_lat, o_busy, o_stall);
            e = exp_q.pop_front();
            $display("aligned[%0d] st=%b addr=%h err=%b rdata=%h lat=%0d", i, tbl[i].st, tbl[i].addr, o_err, o_rd, o_lat);
            checks++; if (o_err !== e.err) begin failures++; $display("FAIL aligned_err[%0d] got=%b exp=%b", i, o_err, e.err); end
            checks++; if (o_rd !== e.rdata) begin failures++; $display("FAIL aligned_rdata[%0d] got=%h exp=%h", i, o_rd, e.rdata); end
            checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL aligned_latency[%0d] got=%0d exp=%0d", i, o_lat, e.lat); end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL aligned_ready_while_busy[%0d] got=%b exp=0", i, o_busy); end
            while (exp_wr.size() > 0) begin
                ew = exp_wr.pop_front();
                ow = (obs_wr.size() > 0) ? obs_wr.pop_front() : 48'hx;
                checks++; if (ow !== ew) begin failures++; $display("FAIL aligned_write[%0d] got=%h exp=%h", i, ow, ew); end
            end
            checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL aligned_extra_writes[%0d] got=%0d exp=0", i, obs_wr.size()); obs_wr.delete(); end
        end
    endtask

    task automatic test_byte_lanes;
        req_t tbl[$];
        exp_t e;
        logic o_err, o_busy;
        logic [31:0] o_rd;
        int o_lat, o_stall;
        logic [47:0] ew, ow;
        tbl = '{'{1'b1, 2'd0, 1'b0, 32'h23, 32'h000000A5},
                '{1'b0, 2'd0, 1'b0, 32'h23, 32'h0},
                '{1'b0, 2'd0, 1'b1, 32'h23, 32'h0},
                '{1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF5A},
                '{1'b0, 2'd0, 1'b0, 32'h21, 32'h0},
                '{1'b1, 2'd1, 1'b0, 32'h26, 32'h1234C001},
                '{1'b0, 2'd1, 1'b0, 32'h26, 32'h0},
                '{1'b0, 2'd1, 1'b1, 32'h26, 32'h0},
                '{1'b0, 2'd2, 1'b1, 32'h24, 32'h0}};
        foreach (tbl[i]) begin
            predict(tbl[i]);
            issue(tbl[i], o_err, o_rd, o_lat, o_busy, o_stall);
            e = exp_q.pop_front();
            $display("byte_lanes[%0d] st=%b sz=%0d uns=%b addr=%h err=%b rdata=%h lat=%0d", i, tbl[i].st, tbl[i].sz, tbl[i].uns, tbl[i].addr, o_err, o_rd, o_lat);
            checks++; if (o_err !== e.err) begin failures++; $display("FAIL byte_err[%0d] got=%b exp=%b", i, o_err, e.err); end
            checks++; if (o_rd !== e.rdata) begin failures++; $display("FAIL byte_rdata[%0d] got=%h exp=%h", i, o_rd, e.rdata); end
            checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL byte_latency[%0d] got=%0d exp=%0d", i, o_lat, e.lat); end
            while (exp_wr.size() > 0) begin
                ew = exp_wr.pop_front();
                ow = (obs_wr.size() > 0) ? obs_wr.pop_front() : 48'hx;
                checks++; if (ow !== ew) begin failures++; $display("FAIL byte_write[%0d] got=%h exp=%h", i, ow, ew); end
            end
            checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL byte_extra_writes[%0d] got=%0d exp=0", i, obs_wr.size()); obs_wr.delete(); end
        end
    endtask

    task automatic test_split;
        req_t tbl[$];
        exp_t e;
        logic o_err, o_busy;
        logic [31:0] o_rd;
        int o_lat, o_stall;
        logic [47:0] ew, ow;
        tbl = '{'{1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344},
                '{1'b0, 2'd2, 1'b0, 32'h0E, 32'h0},
                '{1'b1, 2'd0, 1'b0, 32'h0B, 32'h00000080},
                '{1'b1, 2'd0, 1'b0, 32'h0C, 32'h0000007F},
                '{1'b0, 2'd1, 1'b0, 32'h0B, 32'h0},
                '{1'b1, 2'd0, 1'b0, 32'h0C, 32'h000000FF},
                '{1'b0, 2'd1, 1'b0, 32'h0B, 32'h0},
                '{1'b0, 2'd1, 1'b1, 32'h0B, 32'h0},
                '{1'b1, 2'd1, 1'b0, 32'h33, 32'hABCD8765},
                '{1'b0, 2'd2, 1'b0, 32'h31, 32'h0}};
        foreach (tbl[i]) begin
            predict(tbl[i]);
            issue(tbl[i], o_err, o_rd, o_lat, o_busy, o_stall);
            e = exp_q.pop_front();
            $display("split[%0d] st=%b sz=%0d addr=%h err=%b rdata=%h lat=%0d", i, tbl[i].st, tbl[i].sz, tbl[i].addr, o_err, o_rd, o_lat);
            checks++; if (o_err !== e.err) begin failures++; $display("FAIL split_err[%0d] got=%b exp=%b", i, o_err, e.err); end
            checks++; if (o_rd !== e.rdata) begin failures++; $display("FAIL split_rdata[%0d] got=%h exp=%h", i, o_rd, e.rdata); end
            checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL split_latency[%0d] got=%0d exp=%0d", i, o_lat, e.lat); end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL split_ready_while_busy[%0d] got=%b exp=0", i, o_busy); end
            while (exp_wr.size() > 0) begin
                ew = exp_wr.pop_front();
                ow = (obs_wr.size() > 0) ? obs_wr.pop_front() : 48'hx;
                checks++; if (ow !== ew) begin failures++; $display("FAIL split_write[%0d] got=%h exp=%h", i, ow, ew); end
            end
            checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL split_extra_writes[%0d] got=%0d exp=0", i, obs_wr.size()); obs_wr.delete(); end
        end
    endtask

    task automatic test_errors;
        req_t tbl[$];
        exp_t e;
        logic o_err, o_busy;
        logic [31:0] o_rd;
        int o_lat, o_stall;
        logic [47:0] ew, ow;
        tbl = '{'{1'b0, 2'd2, 1'b0, 32'h00004000, 32'h0},
                '{1'b1, 2'd1, 1'b0, 32'h00003FFF, 32'h5555AAAA},
                '{1'b0, 2'd3, 1'b0, 32'h00000020, 32'h0},
                '{1'b1, 2'd3, 1'b0, 32'h00000020, 32'hFFFFFFFF},
                '{1'b1, 2'd2, 1'b0, 32'h00003FFD, 32'h01020304},
                '{1'b1, 2'd0, 1'b0, 32'h80000010, 32'h000000EE},
                '{1'b1, 2'd1, 1'b0, 32'h00003FFE, 32'h00009A9B},
                '{1'b0, 2'd1, 1'b0, 32'h00003FFE, 32'h0},
                '{1'b0, 2'd0, 1'b1, 32'h00003FFF, 32'h0}};
        foreach (tbl[i]) begin
            predict(tbl[i]);
            issue(tbl[i], o_err, o_rd, o_lat, o_busy, o_stall);
            e = exp_q.pop_front();
            $display("errors[%0d] st=%b sz=%0d addr=%h err=%b rdata=%h lat=%0d", i, tbl[i].st, tbl[i].sz, tbl[i].addr, o_err, o_rd, o_lat);
            checks++; if (o_err !== e.err) begin failures++; $display("FAIL error_flag[%0d] got=%b exp=%b", i, o_err, e.err); end
            checks++; if (o_rd !== e.rdata) begin failures++; $display("FAIL error_rdata[%0d] got=%h exp=%h", i, o_rd, e.rdata); end
            checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL error_latency[%0d] got=%0d exp=%0d", i, o_lat, e.lat); end
            while (exp_wr.size() > 0) begin
                ew = exp_wr.pop_front();
                ow = (obs_wr.size() > 0) ? obs_wr.pop_front() : 48'hx;
                checks++; if (ow !== ew) begin failures++; $display("FAIL error_write[%0d] got=%h exp=%h", i, ow, ew); end
            end
            checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL error_extra_writes[%0d] got=%0d exp=0", i, obs_wr.size()); obs_wr.delete(); end
        end
    endtask

    task automatic test_back_to_back;
        req_t tbl[$];
        req_t r;
        exp_t e;
        logic o_err, o_busy;
        logic [31:0] o_rd;
        int o_lat, o_stall;
        logic [47:0] ew, ow;
        for (int i = 0; i < 40; i++) begin
            r.st  = 1'($urandom_range(0, 1));
            r.sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r.uns = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       r.addr = 32'h3FF8 + $urandom_range(0, 7);
                1:       r.addr = 32'h00010000 | $urandom_range(0, 63);
                default: r.addr = $urandom_range(0, 63);
            endcase
            r.wd = $urandom;
            tbl.push_back(r);
        end
        foreach (tbl[i]) begin
            predict(tbl[i]);
            issue(tbl[i], o_err, o_rd, o_lat, o_busy, o_stall);
            e = exp_q.pop_front();
            $display("b2b[%0d] st=%b sz=%0d uns=%b addr=%h err=%b rdata=%h lat=%0d", i, tbl[i].st, tbl[i].sz, tbl[i].uns, tbl[i].addr, o_err, o_rd, o_lat);
            checks++; if (o_err !== e.err) begin failures++; $display("FAIL b2b_err[%0d] got=%b exp=%b", i, o_err, e.err); end
            checks++; if (o_rd !== e.rdata) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, o_rd, e.rdata); end
            checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, o_lat, e.lat); end
            checks++; if (o_stall !== 0) begin failures++; $display("FAIL b2b_accept_stall[%0d] got=%0d exp=0", i, o_stall); end
            while (exp_wr.size() > 0) begin
                ew = exp_wr.pop_front();
                ow = (obs_wr.size() > 0) ? obs_wr.pop_front() : 48'hx;
                checks++; if (ow !== ew) begin failures++; $display("FAIL b2b_write[%0d] got=%h exp=%h", i, ow, ew); end
            end
            checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL b2b_extra_writes[%0d] got=%0d exp=0", i, obs_wr.size()); obs_wr.delete(); end
        end
    endtask

    task automatic test_reset_mid;
        req_t tbl[$];
        exp_t e;
        logic o_err, o_busy;
        logic [31:0] o_rd;
        int o_lat, o_stall;
        // Split store that gets abandoned; the reference memory is left untouched
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h1E; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++; if (we !== 1'b1 || mem_op !== 4'b1100) begin failures++; $display("FAIL midreset_issue_lo got we=%b mem_op=%b exp we=1 mem_op=1100", we, mem_op); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL midreset_we got=%b exp=0", we); end
        checks++; if (mem_op !== 4'h0) begin failures++; $display("FAIL midreset_mem_op got=%b exp=0000", mem_op); end
        checks++; if (data_addr !== '0) begin failures++; $display("FAIL midreset_data_addr got=%h exp=0", data_addr); end
        checks++; if (data_write !== 32'h0) begin failures++; $display("FAIL midreset_data_write got=%h exp=0", data_write); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midreset_req_ready got=%b exp=1", req_ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready_after got=%b exp=1", req_ready); end
        checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL midreset_writes got=%0d exp=0", obs_wr.size()); obs_wr.delete(); end
        $display("reset_mid: we=%b mem_op=%b req_ready=%b", we, mem_op, req_ready);
        tbl = '{'{1'b0, 2'd2, 1'b0, 32'h1C, 32'h0},
                '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0}};
        foreach (tbl[i]) begin
            predict(tbl[i]);
            issue(tbl[i], o_err, o_rd, o_lat, o_busy, o_stall);
            e = exp_q.pop_front();
            $display("reset_mid_readback[%0d] addr=%h rdata=%h lat=%0d", i, tbl[i].addr, o_rd, o_lat);
            checks++; if (o_rd !== e.rdata) begin failures++; $display("FAIL midreset_readback[%0d] got=%h exp=%h", i, o_rd, e.rdata); end
            checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL midreset_latency[%0d] got=%0d exp=%0d", i, o_lat, e.lat); end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_byte_lanes();
        test_split();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the byte-lane data memory interface: we, mem_op[3:0] byte enables, word address, 32-bit write data, read data valid one cycle after the address is presented.
- Accepts byte-addressed RV32I load/store requests from the execute stage and returns aligned, extended load data.
- Generates byte enables and lane-shifted write data for the memory.
- Splits misaligned accesses that straddle a word boundary into two memory cycles.
- Flags out-of-range or illegal-size accesses without touching memory.

Parameters:
- ADDR_WIDTH, 12, word-address width of the attached data memory (capacity 4*2^ADDR_WIDTH bytes).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at rising edge
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend (LBU/LHU), 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse, request complete
- resp_err  out  1  qualified by resp_valid; range or size error
- resp_rdata  out  32  qualified by resp_valid; load result, 0 for stores and errors
- we  out  1  memory write enable
- mem_op  out  4  memory byte enables
- data_addr  out  ADDR_WIDTH  memory word address
- data_write  out  32  memory write data, lane-positioned
- data_read  in  32  memory read data for address presented previous cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; we=0; mem_op=0; data_addr=0; data_write=0. Reset mid-access abandons it; no further memory writes are issued.
- Accept: latch the request only in IDLE on req_valid.
- Offset: o = req_addr[1:0]. Word address w = req_addr[ADDR_WIDTH+1:2].
- Size mask: m = 0001 (byte), 0011 (half), 1111 (word). Mask is the 8-bit value m<<o; lo_mask = [3:0], hi_mask = [7:4]. split = (hi_mask != 0).
- Write lanes: the 64-bit value req_wdata<<(8*o) supplies lo_data = [31:0] and hi_data = [63:32].
- Error: resp_err=1 if size==11, any address bit above ADDR_WIDTH+1 is set, or split with w = 2^ADDR_WIDTH-1 (no wrap-around). Errors go IDLE->RESP with no memory cycle; we stays 0.
- States:
  - IDLE: req_ready=1.
  - ISSUE_LO: data_addr=w, mem_op=lo_mask, we=req_store, data_write=lo_data.
  - ISSUE_HI: data_addr=w+1, mem_op=hi_mask, we=req_store, data_write=hi_data; for loads, capture data_read as lo_word.
  - COLLECT: capture data_read (hi_word if split, else lo_word).
  - RESP: resp_valid=1.
- Transitions:
  - IDLE -> ISSUE_LO on accept without error; IDLE -> RESP on error.
  - ISSUE_LO -> ISSUE_HI if split; else COLLECT for loads, RESP for stores.
  - ISSUE_HI -> COLLECT for loads, RESP for stores.
  - COLLECT -> RESP; RESP -> IDLE.
- Outside ISSUE_LO/ISSUE_HI: we=0, mem_op=0; data_addr and data_write hold their last values.
- Load result: the 64-bit value {hi_word, lo_word} >> (8*o), with hi_word=0 when not split.
  - Take [7:0] or [15:0] or [31:0] by size.
  - Sign- or zero-extend per req_unsigned. Word loads ignore req_unsigned.
- resp_rdata and resp_err are registered on entry to RESP and hold until the next RESP.
- Latency, accept edge to resp_valid: aligned load 3 cycles, split load 4, aligned store 2, split store 3, error 1.
- req_ready=0 from accept until return to IDLE; the earliest next accept is the cycle after RESP.
- Requests are never dropped or reordered.

Test Plan:
- Aligned SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> one cycle we=1, mem_op=1111, data_addr=4; load returns 0xDEADBEEF, resp_err=0, 3-cycle latency.
- SB 0x23 data 0x000000A5, then LB 0x23 / LBU 0x23 -> mem_op=1000, data_write[31:24]=A5; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- Split SW 0x0E data 0x11223344 -> cycle 1: addr 3, mem_op=1100, data_write=0x33440000; cycle 2: addr 4, mem_op=0011, data_write=0x00001122. Then LW 0x0E returns 0x11223344 after 4 cycles.
- Split LH 0x0B over bytes 0x80 (at 0x0B) and 0x7F (at 0x0C) -> returns 0x00007F80; LH of 0xFF80 returns 0xFFFF_FF80.
- Errors: LW 0x4000 (ADDR_WIDTH=12), SH 0x3FFF, req_size=11 -> resp_err=1 after 1 cycle, we never asserted, resp_rdata=0.
- Reset asserted during ISSUE_LO of a split store -> outputs immediately return to reset values; second half never written; after release, req_ready=1.
